s_des_cbc_stream: RTL
=====================

Name: s_des_cbc_stream

Overview:
- Sequential front-end that feeds the team's combinational S-DES encrypt core (S_DES_Encrypt).
- Accepts a plaintext byte stream over valid/ready and applies CBC chaining: core input = byte XOR previous ciphertext, or IV for the first byte of a message.
- Buffers ciphertext in a 2-entry output FIFO with valid/ready and last-flag passthrough.
- Holds the 10-bit key and 8-bit IV registers on behalf of the downstream core.

Parameters:
- P_10, 40'h7583609124, key P10 permutation; passed to core.
- P_8, 40'h47362501, key P8 permutation; passed to core.
- I_P, 40'h62574031, initial permutation; passed to core.
- I_P_1, 40'h47531602, inverse IP; passed to core.
- E_P, 40'h03212103, expansion permutation; passed to core.
- P_4, 40'h2013, P4 permutation; passed to core.
- S_0, 32'h1B87C493, S-box 0 table; passed to core.
- S_1, 32'h4EE427DE, S-box 1 table; passed to core.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_load  in  1  pulse: capture key_in.
- key_in  in  10  S-DES key.
- iv_load  in  1  pulse: capture iv_in into iv_reg and chain_reg.
- iv_in  in  8  initialisation vector.
- in_valid  in  1  plaintext byte valid.
- in_ready  out  1  block can accept a byte.
- in_data  in  8  plaintext byte.
- in_last  in  1  final byte of message.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  8  ciphertext byte.
- out_last  out  1  last flag of head byte.
- key_valid  out  1  a key has been loaded since reset.

Behaviour:
- Reset values: key_reg=0, iv_reg=0, chain_reg=0, key_valid=0, FIFO empty (count=0), out_valid=0, out_data=0, out_last=0, in_ready=0.
- FSM: NOKEY -> RUN on key_load. RUN stays in RUN. Only reset returns to NOKEY.
- key_load in RUN reloads the key. Bytes already in the FIFO are unaffected.
- in_ready = (state==RUN) && count<2 && !key_load && !iv_load.
  - Registered-path only; out_ready never combinationally affects in_ready.
- Accept condition: in_valid && in_ready. On accept:
  - core input = in_data ^ chain_reg, core key = key_reg.
  - The core's ciphertext C is pushed to the FIFO with in_last.
  - chain_reg <= in_last ? iv_reg : C.
- Latency: a byte accepted at edge N appears on out_valid/out_data after edge N (1 cycle) if the FIFO was empty.
- Throughput: 1 byte/cycle sustained while out_ready=1.
- Pop: out_valid && out_ready. Head advances.
- Simultaneous push and pop: count unchanged, order preserved.
- FIFO full (count=2): in_ready=0. Input data is held by upstream per valid/ready; the block never drops a byte.
- Empty: out_valid=0, out_data/out_last hold their last value.
- iv_load: iv_reg<=iv_in and chain_reg<=iv_in. No accept occurs that cycle, since in_ready is gated.
- key_load and iv_load in the same cycle: both take effect.
- Reset mid-stream: FIFO cleared, key_valid=0. Any byte in flight is lost.

Optional Feature:
- Macro: S_DES_CBC_STATS_EN.
- Defined:
  - Adds out port byte_count[15:0], counting accepted bytes; wraps 16'hFFFF->0.
  - Adds out port msg_count[15:0], counting accepted in_last bytes; wraps.
  - Both counters reset to 0 and also clear on key_load.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package s_des_pkg holds:
  - the default permutation and S-box constants listed above;
  - FIFO depth localparam FIFO_DEPTH=2;
  - FSM state enum {NOKEY, RUN}.
- One natural sub-module: s_des_out_fifo (2-entry, 9-bit wide: data+last, valid/ready).
- The combinational core is instantiated directly.

Test Plan:
- Reset, then in_valid=1 with no key: in_ready=0, out_valid=0, key_valid=0.
- key=10'b1010000010, iv=8'h00, single byte 8'b10010111 with in_last=1: out_data=8'h38, out_last=1 one cycle after accept; chain_reg returns to 8'h00.
- Same key, iv=8'h00, two-byte message 8'h97 then 8'h97^8'h38=8'hAF: both outputs 8'h38, confirming chaining.
- Hold out_ready=0 and stream 3 bytes: first two accepted, in_ready=0 on the third. Release out_ready: bytes emerge in order, no loss or duplication.
- Continuous stream with out_ready=1: one accept and one pop per cycle, count stays 1.
- Assert rst_n=0 mid-message with FIFO holding 2 bytes: out_valid=0 immediately (asynchronously), key_valid=0. After release, in_ready=0 until key_load.

Source files
------------

// File: rtl/s_des_pkg.sv
// Shared constants for the S-DES CBC stream front-end: default core tables,
// output FIFO depth, front-end state encoding and the table-driven permute helper.
package s_des_pkg;

    // Each hex digit (MSB first) is the LSB-indexed source bit of the matching output bit.
    localparam logic [39:0] P10_DEF  = 40'h7583609124;
    localparam logic [39:0] P8_DEF   = 40'h47362501;
    localparam logic [39:0] IP_DEF   = 40'h62574031;
    localparam logic [39:0] IPI_DEF  = 40'h47531602;
    localparam logic [39:0] EP_DEF   = 40'h03212103;
    localparam logic [39:0] P4_DEF   = 40'h2013;
    // S-box tables: 16 two-bit entries, row-major, entry 0 in the top bits.
    localparam logic [31:0] S0_DEF   = 32'h1B87C493;
    localparam logic [31:0] S1_DEF   = 32'h4EE427DE;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {NOKEY, RUN} state_t;

    // out[j] = v[digit j]; bits at and above n are left zero.
    function automatic logic [9:0] perm(input logic [9:0] v, input logic [39:0] tbl, input int n);
        logic [9:0] o;
        o = '0;
        for (int j = 0; j < 10; j++) begin
            if (j < n) o[j] = v[tbl[4*j +: 4]];
        end
        return o;
    endfunction

endpackage

// File: rtl/S_DES_Encrypt.sv
// Combinational S-DES encryption core (two Feistel rounds, on-the-fly key schedule).
// S_0 serves the low nibble of the expanded half, S_1 the high nibble.
module S_DES_Encrypt
    import s_des_pkg::*;
#(
    parameter logic [39:0] P_10  = P10_DEF,
    parameter logic [39:0] P_8   = P8_DEF,
    parameter logic [39:0] I_P   = IP_DEF,
    parameter logic [39:0] I_P_1 = IPI_DEF,
    parameter logic [39:0] E_P   = EP_DEF,
    parameter logic [39:0] P_4   = P4_DEF,
    parameter logic [31:0] S_0   = S0_DEF,
    parameter logic [31:0] S_1   = S1_DEF
) (
    input  logic [9:0] key,
    input  logic [7:0] plaintext,
    output logic [7:0] ciphertext
);

    logic [9:0] p10, ls1, ls3;
    logic [7:0] k1, k2, ip_out;
    logic [3:0] r1, l2;

    // Row is the outer bit pair, column the inner pair of the nibble.
    function automatic logic [1:0] sbox(input logic [3:0] x, input logic [31:0] tbl);
        logic [3:0] idx;
        idx = {x[3], x[0], x[2], x[1]};
        return tbl[{~idx, 1'b0} +: 2];
    endfunction

    function automatic logic [3:0] fk(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] x;
        x = 8'(perm(10'(r), E_P, 8)) ^ k;
        return 4'(perm(10'({sbox(x[7:4], S_1), sbox(x[3:0], S_0)}), P_4, 4));
    endfunction

    always_comb begin
        p10    = perm(key, P_10, 10);
        ls1    = {p10[8:5], p10[9], p10[3:0], p10[4]};
        ls3    = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
        k1     = 8'(perm(ls1, P_8, 8));
        k2     = 8'(perm(ls3, P_8, 8));
        ip_out = 8'(perm(10'(plaintext), I_P, 8));
        // Round 1 output is swapped; round 2 is not.
        r1     = ip_out[7:4] ^ fk(ip_out[3:0], k1);
        l2     = ip_out[3:0] ^ fk(r1, k2);
    end

    assign ciphertext = 8'(perm(10'({l2, r1}), I_P_1, 8));

endmodule

// File: rtl/s_des_out_fifo.sv
// Two-entry head/tail output FIFO; the head register keeps its last value when
// the FIFO drains so out_data is stable while empty.
module s_des_out_fifo
    import s_des_pkg::*;
#(
    parameter int W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0] head, tail;
    logic         wr, rd;

    assign wr        = push && (count < CNT_W'(FIFO_DEPTH));
    assign rd        = out_ready && (count != '0);
    assign out_valid = (count != '0);
    assign head_data = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count + CNT_W'(wr) - CNT_W'(rd);
            if (rd) begin
                if (count == CNT_W'(2)) head <= tail;
                else if (wr)            head <= push_data;
            end else if (wr) begin
                if (count == '0) head <= push_data;
                else             tail <= push_data;
            end
        end
    end

endmodule

// File: rtl/s_des_cbc_stream.sv
// CBC front-end for S_DES_Encrypt: key/IV registers, chaining, 2-deep output FIFO.
// Define S_DES_CBC_STATS_EN to add byte_count/msg_count statistics ports.
module s_des_cbc_stream
    import s_des_pkg::*;
#(
    parameter logic [39:0] P_10  = P10_DEF,
    parameter logic [39:0] P_8   = P8_DEF,
    parameter logic [39:0] I_P   = IP_DEF,
    parameter logic [39:0] I_P_1 = IPI_DEF,
    parameter logic [39:0] E_P   = EP_DEF,
    parameter logic [39:0] P_4   = P4_DEF,
    parameter logic [31:0] S_0   = S0_DEF,
    parameter logic [31:0] S_1   = S1_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [9:0]  key_in,
    input  logic        iv_load,
    input  logic [7:0]  iv_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        key_valid
`ifdef S_DES_CBC_STATS_EN
    ,
    output logic [15:0] byte_count,
    output logic [15:0] msg_count
`endif
);

    state_t           state, state_nxt;
    logic [9:0]       key_reg;
    logic [7:0]       iv_reg, chain_reg, core_ct;
    logic [CNT_W-1:0] count;
    logic [8:0]       head_data;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= NOKEY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == NOKEY && key_load) state_nxt = RUN;
    end

    // Loads block acceptance so a byte never chains against a half-updated key/IV.
    assign in_ready = (state == RUN) && (count < CNT_W'(FIFO_DEPTH)) && !key_load && !iv_load;
    assign accept   = in_valid && in_ready;

    S_DES_Encrypt #(
        .P_10(P_10), .P_8(P_8), .I_P(I_P), .I_P_1(I_P_1),
        .E_P(E_P), .P_4(P_4), .S_0(S_0), .S_1(S_1)
    ) u_core (
        .key        (key_reg),
        .plaintext  (in_data ^ chain_reg),
        .ciphertext (core_ct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= '0;
            iv_reg    <= '0;
            chain_reg <= '0;
            key_valid <= 1'b0;
        end else begin
            if (key_load) begin
                key_reg   <= key_in;
                key_valid <= 1'b1;
            end
            if (iv_load) begin
                iv_reg    <= iv_in;
                chain_reg <= iv_in;
            end else if (accept) begin
                chain_reg <= in_last ? iv_reg : core_ct;
            end
        end
    end

    s_des_out_fifo #(.W(9)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data ({in_last, core_ct}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .head_data (head_data),
        .count     (count)
    );

    assign out_data = head_data[7:0];
    assign out_last = head_data[8];

`ifdef S_DES_CBC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= '0;
            msg_count  <= '0;
        end else if (key_load) begin
            byte_count <= '0;
            msg_count  <= '0;
        end else if (accept) begin
            byte_count <= byte_count + 16'd1;
            if (in_last) msg_count <= msg_count + 16'd1;
        end
    end
`endif

endmodule
